alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational 16-bit ALU.
- Accepts one operation at a time on a valid/ready input port and returns result plus flags on a valid/ready output port.
- Logic and add/sub ops complete in one cycle.
- Shifts iterate one bit per cycle; multiply is a WIDTH-cycle shift-add.
- Sits between the decode stage and the register-file writeback.

---
 rtl/alu_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/add/sub, bit-serial shifts,
// WIDTH-cycle shift-add multiply. One operation in flight at a time.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    output logic             out_c,
    output logic             out_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_WIDTH = CW'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d, err_q, err_d;

    logic [WIDTH:0]       sum_s, diff_s, mul_add_s, shift_s;
    logic [2*WIDTH-1:0]   mul_step_s;
    logic [SHW-1:0]       amt_s;
    logic                 fin_load_s, fin_c_s, fin_v_s, fin_err_s;
    logic [WIDTH-1:0]     fin_res_s;

    // One-bit shift step: returns {bit shifted out, shifted value}.
    function automatic logic [WIDTH:0] shift_one(input logic [3:0] op, input logic [WIDTH-1:0] val);
        logic [WIDTH:0] r;
        case (op)
            OP_SHL:  r = {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
            OP_SHR:  r = {val[0], 1'b0, val[WIDTH-1:1]};
            OP_SRA:  r = {val[0], val[WIDTH-1], val[WIDTH-1:1]};
            default: r = {1'b0, val};
        endcase
        return r;
    endfunction

    assign amt_s      = in_b[SHW-1:0];
    assign sum_s      = {1'b0, in_a} + {1'b0, in_b};
    assign diff_s     = {1'b0, in_a} - {1'b0, in_b};
    // Multiplier sits in the low half of prod_q and drains out of bit 0.
    assign mul_add_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                      + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_step_s = {mul_add_s, prod_q[WIDTH-1:1]};
    assign shift_s    = shift_one(op_q, a_q);

    // Next-state, datapath and final-result selection.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        res_d      = res_q;
        z_d        = z_q;
        n_d        = n_q;
        v_d        = v_q;
        c_d        = c_q;
        err_d      = err_q;
        fin_load_s = 1'b0;
        fin_res_s  = {WIDTH{1'b0}};
        fin_c_s    = 1'b0;
        fin_v_s    = 1'b0;
        fin_err_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = in_op;
                    case (in_op)
                        OP_ADD: begin
                            fin_load_s = 1'b1;
                            fin_res_s  = sum_s[WIDTH-1:0];
                            fin_c_s    = sum_s[WIDTH];
                            fin_v_s    = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                                         (sum_s[WIDTH-1] != in_a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            fin_load_s = 1'b1;
                            fin_res_s  = diff_s[WIDTH-1:0];
                            fin_c_s    = diff_s[WIDTH];
                            fin_v_s    = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                                         (diff_s[WIDTH-1] != in_a[WIDTH-1]);
                        end
                        OP_AND: begin
                            fin_load_s = 1'b1;
                            fin_res_s  = in_a & in_b;
                        end
                        OP_OR: begin
                            fin_load_s = 1'b1;
                            fin_res_s  = in_a | in_b;
                        end
                        OP_XOR: begin
                            fin_load_s = 1'b1;
                            fin_res_s  = in_a ^ in_b;
                        end
                        OP_NOT: begin
                            fin_load_s = 1'b1;
                            fin_res_s  = ~in_a;
                        end
                        OP_SHL, OP_SHR, OP_SRA: begin
                            if (amt_s == {SHW{1'b0}}) begin
                                fin_load_s = 1'b1;
                                fin_res_s  = in_a;
                            end else begin
                                a_d     = in_a;
                                cnt_d   = CW'(amt_s);
                                state_d = S_BUSY;
                            end
                        end
                        OP_MUL: begin
                            a_d     = in_a;
                            prod_d  = {{WIDTH{1'b0}}, in_b};
                            cnt_d   = CNT_WIDTH;
                            state_d = S_BUSY;
                        end
                        default: begin
                            fin_load_s = 1'b1;
                            fin_err_s  = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q == OP_MUL) begin
                    prod_d = mul_step_s;
                    if (cnt_q == CNT_ONE) begin
                        fin_load_s = 1'b1;
                        fin_res_s  = mul_step_s[WIDTH-1:0];
                        fin_v_s    = |mul_step_s[2*WIDTH-1:WIDTH];
                    end else begin
                        fin_load_s = 1'b0;
                    end
                end else begin
                    a_d = shift_s[WIDTH-1:0];
                    if (cnt_q == CNT_ONE) begin
                        fin_load_s = 1'b1;
                        fin_res_s  = shift_s[WIDTH-1:0];
                        fin_c_s    = shift_s[WIDTH];
                    end else begin
                        fin_load_s = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flags are always derived from the final result being loaded.
        if (fin_load_s) begin
            state_d = S_DONE;
            res_d   = fin_res_s;
            z_d     = (fin_res_s == {WIDTH{1'b0}});
            n_d     = fin_res_s[WIDTH-1];
            v_d     = fin_v_s;
            c_d     = fin_c_s;
            err_d   = fin_err_s;
        end else begin
            res_d   = res_d;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            a_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            prod_q  <= {(2*WIDTH){1'b0}};
            res_q   <= {WIDTH{1'b0}};
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = res_q;
    assign out_z      = z_q;
    assign out_n      = n_q;
    assign out_v      = v_q;
    assign out_c      = c_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus random bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_z, out_n, out_v, out_c, out_err;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_z(out_z), .out_n(out_n), .out_v(out_v), .out_c(out_c), .out_err(out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definitions of each opcode.
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic v, output logic c,
                         output logic err, output int lat);
        int sa, sb, sr, k;
        logic [16:0] s;
        logic [31:0] p;
        logic signed [15:0] as16;
        sa = $signed(a); sb = $signed(b); k = int'(b[3:0]);
        as16 = a;
        r = 16'h0; v = 1'b0; c = 1'b0; err = 1'b0; lat = 1;
        case (op)
            4'd0: begin s = 17'(a) + 17'(b); r = s[15:0]; c = s[16];
                        sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            4'd1: begin r = a - b; c = (a < b);
                        sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin r = a << k; c = (k > 0) ? a[16-k] : 1'b0; lat = k + 1; end
            4'd7: begin r = a >> k; c = (k > 0) ? a[k-1] : 1'b0; lat = k + 1; end
            4'd8: begin r = as16 >>> k; c = (k > 0) ? a[k-1] : 1'b0; lat = k + 1; end
            4'd9: begin p = 32'(a) * 32'(b); r = p[15:0]; v = (p > 32'h0000FFFF); lat = 17; end
            default: err = 1'b1;
        endcase
    endtask

    // Issue one operation, scramble inputs after accept, check latency/result/flags.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        logic [15:0] er; logic ev, ec, ee; int elat; int t; int lat;
        model(op, a, b, er, ev, ec, ee, elat);
        t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 4'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_res"}, 32'(out_result), 32'(er));
        chk({tag, "_zn"},  32'({out_z, out_n}), 32'({(er == 16'h0), er[15]}));
        chk({tag, "_vc"},  32'({out_v, out_c}), 32'({ev, ec}));
        chk({tag, "_err"}, 32'(out_err), 32'(ee));
    endtask

    initial begin
        logic seen; logic [15:0] r0; logic [3:0] f0;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_a = 16'h0; in_b = 16'h0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_flags", 32'({out_z, out_n, out_v, out_c, out_err}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add_ovf",   4'd0, 16'h7FFF, 16'h0001);
        do_op("add_carry", 4'd0, 16'hFFFF, 16'h0001);
        do_op("sub_zero",  4'd1, 16'h0003, 16'h0003);
        do_op("sub_borrow",4'd1, 16'h0000, 16'h0001);
        do_op("mul_small", 4'd9, 16'h0003, 16'h0005);
        do_op("mul_ovf",   4'd9, 16'h0100, 16'h0100);
        do_op("shl4",      4'd6, 16'h8003, 16'h0004);
        do_op("sra15",     4'd8, 16'h8000, 16'h000F);
        do_op("shr1",      4'd7, 16'h0001, 16'h0001);
        do_op("shl0",      4'd6, 16'hA5C3, 16'h0010);
        do_op("illegal",   4'hC, 16'h1234, 16'h5678);
        do_op("after_ill", 4'd4, 16'h1234, 16'h00FF);

        // Reset in the middle of a multiply: nothing may emerge afterwards.
        in_valid = 1'b1; in_op = 4'd9; in_a = 16'h1234; in_b = 16'h0007;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; seen = seen | out_valid; end
        chk("midrst_novalid", 32'(seen), 32'd0);
        chk("midrst_ready2", 32'(in_ready), 32'd1);
        do_op("post_rst", 4'd0, 16'h0001, 16'h0001);

        // Backpressure: result held while out_ready is low.
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_op("bp_and", 4'd2, 16'hF0F0, 16'h0FF0);
        r0 = out_result; f0 = {out_z, out_n, out_v, out_c};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom); in_a = 16'($urandom); in_op = 4'd0;
            @(posedge clk); #1;
            chk("bp_hold_res", 32'(out_result), 32'h00F0);
            chk("bp_hold_flags", 32'({out_z, out_n, out_v, out_c}), 32'(f0));
            chk("bp_hold_vr", 32'({out_valid, in_ready}), 32'b10);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 32'({out_valid, in_ready}), 32'b01);
        chk("bp_res_kept", 32'(r0), 32'h00F0);

        // Random operations against the model.
        for (int i = 0; i < 60; i++) begin
            do_op("rand", 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
